alu_ctrl: RTL and testbench
===========================

ALU_CTRL -- requirements
Module: alu_ctrl

Interface
REQ-001 Parameter MUL_WAIT, default 4: EXEC cycles allowed for Mul (1..15).
REQ-002 Parameter DIV_WAIT, default 8: EXEC cycles allowed for Div (1..15).
REQ-003 clock  in  1  single clock; all state updates on its rising edge.
REQ-004 clear  in  1  reset, synchronous, active-high.
REQ-005 start  in  1  request pulse; sampled only in IDLE.
REQ-006 opcode  in  5  operation code of the request.
REQ-007 inc_pc  in  1  request is PC increment; overrides opcode.
REQ-008 a_in, b_in  in  32 each  request operands.
REQ-009 alu_a, alu_b  out  32 each  registered operands to the ALU.
REQ-010 alu_opcode  out  5, alu_incpc  out  1  registered controls to the ALU.
REQ-011 alu_hi, alu_lo  in  32 each  ALU combinational HI/LO results.
REQ-012 z_hi, z_lo  out  32 each  result registers.
REQ-013 busy  out  1  high in EXEC and DONE.
REQ-014 done  out  1  one-cycle completion pulse.
REQ-015 illegal  out  1  valid with done; request was rejected.

Function
REQ-016 States: IDLE, EXEC, DONE only; encoding from the shared package.
REQ-017 Legal opcodes: Add 00011, Sub 00100, Shr 00101, Shra 00110, Shl 00111, Ror 01000, Rol 01001, And 01010, Or 01011, Mul 01111, Div 10000; all others illegal.
REQ-018 IDLE, start=1 at edge k: capture a_in, b_in, opcode, inc_pc into alu_* registers; load counter with W-1; go to EXEC.
REQ-019 W = 1 for inc_pc or single-cycle ops, MUL_WAIT for Mul, DIV_WAIT for Div.
REQ-020 EXEC: counter decrements each edge; at the edge where counter==0, z_hi<=alu_hi, z_lo<=alu_lo, illegal<=0, go to DONE (edge k+W).
REQ-021 Illegal opcode with inc_pc=0: W=1, z_hi/z_lo unchanged, illegal<=1, reach DONE at edge k+1.
REQ-022 DONE: done=1 for exactly one cycle; next edge returns to IDLE; illegal holds until next completion.
REQ-023 start in EXEC or DONE is ignored and never queued.
REQ-024 alu_* registers hold stable from edge k until the next accepted start.
REQ-025 Non-Mul/Div legal ops and inc_pc load z_hi with the ALU HI value (zero by ALU contract).

Reset
REQ-026 clear=1 at an edge: state IDLE; counter, alu_a, alu_b, alu_opcode, alu_incpc, z_hi, z_lo, busy, done, illegal all 0.
REQ-027 clear overrides start and aborts any operation in progress; no done pulse for aborted work.

Configuration
REQ-028 Macro ALU_CTRL_DIV_EN defined: Div legal with W=DIV_WAIT.
REQ-029 ALU_CTRL_DIV_EN undefined: Div treated as illegal per REQ-021; DIV_WAIT unused.

Structure
REQ-030 Package alu_ctrl_pkg holds opcode constants and the state type.
REQ-031 One combinational sub-module alu_ctrl_decode: opcode, inc_pc -> legal flag and W.

Verification
REQ-032 Add: a_in=5, b_in=7, start at edge k -> done at k+1 cycle, z_lo=12, z_hi=0, illegal=0.
REQ-033 Mul, MUL_WAIT=4: a_in=0x10000, b_in=0x10000 -> done after edge k+4, z_hi=1, z_lo=0; start pulses mid-EXEC ignored.
REQ-034 Opcode 11111 -> done after edge k+1, illegal=1, z_hi/z_lo unchanged.
REQ-035 Div 100/7 with ALU_CTRL_DIV_EN, DIV_WAIT=8 -> done after edge k+8, z_lo=14, z_hi=2; without macro -> illegal=1 after edge k+1.
REQ-036 clear asserted at EXEC cycle 2 of a Mul -> next cycle IDLE, all outputs 0, no done pulse.
REQ-037 Back-to-back: start held high continuously -> new request accepted only in IDLE, exactly one done per accepted request.

Source files
------------

// File: rtl/alu_ctrl_pkg.sv
// alu_ctrl_pkg: opcode constants and FSM state type shared by the ALU controller.
package alu_ctrl_pkg;

  localparam int OPC_W = 5;
  localparam int CNT_W = 4;

  localparam logic [OPC_W-1:0] OP_ADD  = 5'b00011;
  localparam logic [OPC_W-1:0] OP_SUB  = 5'b00100;
  localparam logic [OPC_W-1:0] OP_SHR  = 5'b00101;
  localparam logic [OPC_W-1:0] OP_SHRA = 5'b00110;
  localparam logic [OPC_W-1:0] OP_SHL  = 5'b00111;
  localparam logic [OPC_W-1:0] OP_ROR  = 5'b01000;
  localparam logic [OPC_W-1:0] OP_ROL  = 5'b01001;
  localparam logic [OPC_W-1:0] OP_AND  = 5'b01010;
  localparam logic [OPC_W-1:0] OP_OR   = 5'b01011;
  localparam logic [OPC_W-1:0] OP_MUL  = 5'b01111;
  localparam logic [OPC_W-1:0] OP_DIV  = 5'b10000;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/alu_ctrl_decode.sv
// alu_ctrl_decode: combinational request decode -> legal flag and EXEC length minus one.
// Div support is compiled in only when ALU_CTRL_DIV_EN is defined.
module alu_ctrl_decode
  import alu_ctrl_pkg::*;
#(
  parameter int MUL_WAIT = 4,
  parameter int DIV_WAIT = 8
) (
  input  logic [OPC_W-1:0] opcode,
  input  logic             inc_pc,
  output logic             legal,
  output logic [CNT_W-1:0] wait_m1
);

`ifdef ALU_CTRL_DIV_EN
  localparam bit DIV_EN = 1'b1;
`else
  localparam bit DIV_EN = 1'b0;
`endif

  localparam logic [CNT_W-1:0] MUL_WM1 = CNT_W'(MUL_WAIT - 1);
  localparam logic [CNT_W-1:0] DIV_WM1 = CNT_W'(DIV_WAIT - 1);

  // inc_pc wins over opcode; rejected requests still take one EXEC cycle
  always_comb begin
    legal   = 1'b0;
    wait_m1 = '0;
    if (inc_pc) begin
      legal = 1'b1;
    end else begin
      case (opcode)
        OP_ADD, OP_SUB, OP_SHR, OP_SHRA, OP_SHL,
        OP_ROR, OP_ROL, OP_AND, OP_OR: legal = 1'b1;
        OP_MUL: begin
          legal   = 1'b1;
          wait_m1 = MUL_WM1;
        end
        OP_DIV: begin
          legal   = DIV_EN;
          wait_m1 = DIV_EN ? DIV_WM1 : '0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/alu_ctrl.sv
// alu_ctrl: IDLE/EXEC/DONE sequencer that registers a request into the ALU,
// waits the op-dependent number of cycles and latches the HI/LO result.
// Build option: define ALU_CTRL_DIV_EN to make Div a legal (DIV_WAIT-cycle) op.
module alu_ctrl
  import alu_ctrl_pkg::*;
#(
  parameter int MUL_WAIT = 4,
  parameter int DIV_WAIT = 8
) (
  input  logic             clock,
  input  logic             clear,
  input  logic             start,
  input  logic [OPC_W-1:0] opcode,
  input  logic             inc_pc,
  input  logic [31:0]      a_in,
  input  logic [31:0]      b_in,
  output logic [31:0]      alu_a,
  output logic [31:0]      alu_b,
  output logic [OPC_W-1:0] alu_opcode,
  output logic             alu_incpc,
  input  logic [31:0]      alu_hi,
  input  logic [31:0]      alu_lo,
  output logic [31:0]      z_hi,
  output logic [31:0]      z_lo,
  output logic             busy,
  output logic             done,
  output logic             illegal
);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             req_legal;
  logic             dec_legal;
  logic [CNT_W-1:0] dec_wm1;

  alu_ctrl_decode #(
    .MUL_WAIT (MUL_WAIT),
    .DIV_WAIT (DIV_WAIT)
  ) u_decode (
    .opcode  (opcode),
    .inc_pc  (inc_pc),
    .legal   (dec_legal),
    .wait_m1 (dec_wm1)
  );

  // sequencer: accept in IDLE, count down in EXEC, one-cycle done in DONE
  always_ff @(posedge clock) begin
    if (clear) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      req_legal  <= 1'b0;
      alu_a      <= '0;
      alu_b      <= '0;
      alu_opcode <= '0;
      alu_incpc  <= 1'b0;
      z_hi       <= '0;
      z_lo       <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      illegal    <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          done <= 1'b0;
          if (start) begin
            alu_a      <= a_in;
            alu_b      <= b_in;
            alu_opcode <= opcode;
            alu_incpc  <= inc_pc;
            req_legal  <= dec_legal;
            cnt        <= dec_wm1;
            busy       <= 1'b1;
            state      <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          if (cnt == '0) begin
            // rejected requests leave the result registers untouched
            if (req_legal) begin
              z_hi    <= alu_hi;
              z_lo    <= alu_lo;
              illegal <= 1'b0;
            end else begin
              illegal <= 1'b1;
            end
            done  <= 1'b1;
            state <= ST_DONE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        ST_DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
        default: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_ctrl.sv
// tb_alu_ctrl: table-driven directed check of alu_ctrl with a behavioural ALU stub,
// plus hand sequences for mid-EXEC start, abort by clear and back-to-back starts.
module tb_alu_ctrl;

  logic        clock = 1'b0;
  logic        clear, start, inc_pc;
  logic [4:0]  opcode;
  logic [31:0] a_in, b_in;
  logic [31:0] alu_a, alu_b, alu_hi, alu_lo, z_hi, z_lo;
  logic [4:0]  alu_opcode;
  logic        alu_incpc, busy, done, illegal;

  int checks = 0;
  int errors = 0;

  alu_ctrl #(.MUL_WAIT(4), .DIV_WAIT(8)) dut (
    .clock(clock), .clear(clear), .start(start), .opcode(opcode), .inc_pc(inc_pc),
    .a_in(a_in), .b_in(b_in), .alu_a(alu_a), .alu_b(alu_b), .alu_opcode(alu_opcode),
    .alu_incpc(alu_incpc), .alu_hi(alu_hi), .alu_lo(alu_lo), .z_hi(z_hi), .z_lo(z_lo),
    .busy(busy), .done(done), .illegal(illegal)
  );

  always #5 clock = ~clock;

  // behavioural ALU driven by the controller's registered operands
  logic [63:0] prod;
  always_comb begin
    prod   = 64'(alu_a) * 64'(alu_b);
    alu_hi = '0;
    alu_lo = '0;
    if (alu_incpc) alu_lo = alu_a + 32'd1;
    else case (alu_opcode)
      5'b00011: alu_lo = alu_a + alu_b;
      5'b00100: alu_lo = alu_a - alu_b;
      5'b00111: alu_lo = alu_a << alu_b[4:0];
      5'b01010: alu_lo = alu_a & alu_b;
      5'b01111: begin alu_hi = prod[63:32]; alu_lo = prod[31:0]; end
      5'b10000: if (alu_b != 0) begin alu_lo = alu_a / alu_b; alu_hi = alu_a % alu_b; end
      default: ;
    endcase
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [4:0]  op;
    logic        ipc;
    logic [31:0] a, b;
    int          w;
    logic [31:0] hi, lo;
    logic        ill;
  } vec_t;

  vec_t vecs[10];

  // issue one request and verify latency, results and the single done pulse
  task automatic run_vec(input vec_t v, input int idx);
    int n;
    @(negedge clock);
    opcode = v.op; inc_pc = v.ipc; a_in = v.a; b_in = v.b; start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    check($sformatf("v%0d accept busy", idx), 64'(busy), 64'd1);
    check($sformatf("v%0d alu_opcode", idx), 64'(alu_opcode), 64'(v.op));
    n = 0;
    while (!done && n < 40) begin
      @(posedge clock); #1;
      n++;
    end
    check($sformatf("v%0d latency", idx), 64'(n), 64'(v.w));
    check($sformatf("v%0d z_hi", idx), 64'(z_hi), 64'(v.hi));
    check($sformatf("v%0d z_lo", idx), 64'(z_lo), 64'(v.lo));
    check($sformatf("v%0d illegal", idx), 64'(illegal), 64'(v.ill));
    @(posedge clock); #1;
    check($sformatf("v%0d done+busy drop", idx), {62'd0, done, busy}, 64'd0);
  endtask

  initial begin
    int n, dn;
    clear = 1'b1; start = 1'b0; inc_pc = 1'b0; opcode = '0; a_in = '0; b_in = '0;

    // results of illegal requests repeat the previous entry's z values
    vecs[0] = '{5'b00011, 1'b0, 32'd5,       32'd7,       1, 32'd0, 32'd12,     1'b0};
    vecs[1] = '{5'b00100, 1'b0, 32'd10,      32'd3,       1, 32'd0, 32'd7,      1'b0};
    vecs[2] = '{5'b11111, 1'b1, 32'h100,     32'd0,       1, 32'd0, 32'h101,    1'b0};
    vecs[3] = '{5'b01111, 1'b0, 32'h10000,   32'h10000,   4, 32'd1, 32'd0,      1'b0};
    vecs[4] = '{5'b11111, 1'b0, 32'd9,       32'd9,       1, 32'd1, 32'd0,      1'b1};
    vecs[5] = '{5'b01010, 1'b0, 32'hF0F0,    32'hFF00,    1, 32'd0, 32'hF000,   1'b0};
`ifdef ALU_CTRL_DIV_EN
    vecs[6] = '{5'b10000, 1'b0, 32'd100,     32'd7,       8, 32'd2, 32'd14,     1'b0};
    vecs[7] = '{5'b00111, 1'b0, 32'd1,       32'd4,       1, 32'd0, 32'd16,     1'b0};
`else
    vecs[6] = '{5'b10000, 1'b0, 32'd100,     32'd7,       1, 32'd0, 32'hF000,   1'b1};
    vecs[7] = '{5'b00111, 1'b0, 32'd1,       32'd4,       1, 32'd0, 32'd16,     1'b0};
`endif
    vecs[8] = '{5'b01111, 1'b0, 32'd3,       32'd5,       4, 32'd0, 32'd15,     1'b0};
    vecs[9] = '{5'b00000, 1'b0, 32'd1,       32'd1,       1, 32'd0, 32'd15,     1'b1};

    // reset state, with start asserted to show clear wins
    @(negedge clock); start = 1'b1; opcode = 5'b00011;
    repeat (3) @(posedge clock);
    #1;
    check("reset outputs", {alu_a, alu_b}, 64'd0);
    check("reset ctl", {35'd0, alu_opcode, alu_incpc, z_hi[0], z_lo[0], busy, done, illegal},
          64'd0);
    check("reset z", {z_hi, z_lo}, 64'd0);
    @(negedge clock); clear = 1'b0; start = 1'b0;

    for (int i = 0; i < 10; i++) run_vec(vecs[i], i);

    // Mul with start pulses during EXEC: ignored, operands stay captured
    @(negedge clock);
    opcode = 5'b01111; inc_pc = 1'b0; a_in = 32'd6; b_in = 32'd7; start = 1'b1;
    @(posedge clock); #1;
    opcode = 5'b00011; a_in = 32'd1; b_in = 32'd1;   // start still high into EXEC
    @(posedge clock); #1;
    @(posedge clock); #1;
    start = 1'b0;
    check("mid-exec alu_a", 64'(alu_a), 64'd6);
    check("mid-exec alu_opcode", 64'(alu_opcode), 64'(5'b01111));
    check("mid-exec no done", 64'(done), 64'd0);
    n = 2;
    while (!done && n < 40) begin @(posedge clock); #1; n++; end
    check("mid-exec latency", 64'(n), 64'd4);
    check("mid-exec z", {z_hi, z_lo}, 64'd42);
    dn = 0;
    repeat (6) begin @(posedge clock); #1; if (done) dn++; if (busy) dn++; end
    check("mid-exec not queued", 64'(dn), 64'd0);

    // clear at EXEC cycle 2 of a Mul aborts with no done pulse
    @(negedge clock);
    opcode = 5'b01111; a_in = 32'd2; b_in = 32'd2; start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    @(posedge clock); #1;
    clear = 1'b1;
    @(posedge clock); #1;
    clear = 1'b0;
    check("abort regs", {alu_a, alu_b} | {z_hi, z_lo}, 64'd0);
    check("abort ctl", {57'd0, alu_opcode, alu_incpc, busy, done, illegal} , 64'd0);
    dn = 0;
    repeat (8) begin @(posedge clock); #1; if (done || busy) dn++; end
    check("abort no done", 64'(dn), 64'd0);

    // start held high: Add takes 3 edges per request (accept, complete, return)
    @(negedge clock);
    opcode = 5'b00011; a_in = 32'd5; b_in = 32'd7; start = 1'b1;
    dn = 0; n = 0;
    for (int e = 1; e <= 30; e++) begin
      @(posedge clock); #1;
      if (done) begin
        dn++;
        if (z_lo !== 32'd12) n++;
      end
    end
    start = 1'b0;
    check("b2b done count", 64'(dn), 64'd10);
    check("b2b results", 64'(n), 64'd0);
    repeat (2) @(posedge clock);
    #1;
    check("b2b idle", {62'd0, busy, done}, 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
